// File: rtl/aes_pkg.sv
// Shared AES constants, control encodings and round-transform helpers.
package aes_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned ROUND_W = 4;

  localparam logic AES_128_BIT_KEY = 1'b0;
  localparam logic AES_256_BIT_KEY = 1'b1;

  localparam logic [ROUND_W-1:0] AES128_ROUNDS = 4'ha;
  localparam logic [ROUND_W-1:0] AES256_ROUNDS = 4'he;

  typedef enum logic [2:0] {
    CTRL_IDLE = 3'd0,
    CTRL_INIT = 3'd1,
    CTRL_SBOX = 3'd2,
    CTRL_MAIN = 3'd3
  } enc_state_e;

  typedef enum logic [2:0] {
    UPD_NONE  = 3'd0,
    UPD_INIT  = 3'd1,
    UPD_SBOX  = 3'd2,
    UPD_MAIN  = 3'd3,
    UPD_FINAL = 3'd4
  } update_e;

  function automatic logic [7:0] gm2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] x);
    return gm2(x) ^ x;
  endfunction

  function automatic logic [WORD_W-1:0] mixw(input logic [WORD_W-1:0] w);
    logic [7:0] b0, b1, b2, b3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    return {gm2(b0) ^ gm3(b1) ^ b2 ^ b3,
            b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
            b0 ^ b1 ^ gm2(b2) ^ gm3(b3),
            gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
  endfunction

  function automatic logic [BLOCK_W-1:0] mixcolumns(input logic [BLOCK_W-1:0] d);
    return {mixw(d[127:96]), mixw(d[95:64]), mixw(d[63:32]), mixw(d[31:0])};
  endfunction

  function automatic logic [BLOCK_W-1:0] shiftrows(input logic [BLOCK_W-1:0] d);
    logic [WORD_W-1:0] w0, w1, w2, w3;
    w0 = d[127:96];
    w1 = d[95:64];
    w2 = d[63:32];
    w3 = d[31:0];
    return {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
            w1[31:24], w2[23:16], w3[15:8], w0[7:0],
            w2[31:24], w3[23:16], w0[15:8], w1[7:0],
            w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
  endfunction

  function automatic logic [BLOCK_W-1:0] addroundkey(input logic [BLOCK_W-1:0] d,
                                                     input logic [BLOCK_W-1:0] k);
    return d ^ k;
  endfunction

endpackage

// File: rtl/aes_encipher_block_if.sv
// Handshake, key-memory and shared S-box signals of the encipher block.
interface aes_encipher_block_if;

   logic                          next;
   logic                          keylen;
   logic [aes_pkg::ROUND_W-1:0]   round;
   logic [aes_pkg::BLOCK_W-1:0]   round_key;
   logic [aes_pkg::WORD_W-1:0]    sboxw;
   logic [aes_pkg::WORD_W-1:0]    new_sboxw;
   logic [aes_pkg::BLOCK_W-1:0]   block;
   logic [aes_pkg::BLOCK_W-1:0]   new_block;
   logic                          ready;

   modport slave (
      input  next, keylen, round_key, new_sboxw, block,
      output round, sboxw, new_block, ready
   );

   modport master (
      output next, keylen, round_key, new_sboxw, block,
      input  round, sboxw, new_block, ready
   );

endinterface

// File: rtl/aes_encipher_block.sv
// Iterative AES-128/256 encipher datapath with word-serial SubBytes through a
// borrowed S-box port; remaining round transforms finish in one cycle.
module aes_encipher_block
   import aes_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   aes_encipher_block_if.slave  bus
);

   logic [WORD_W-1:0]  block_w0, block_w1, block_w2, block_w3;
   logic [1:0]         sword_ctr;
   logic [ROUND_W-1:0] round_ctr;
   logic               keylen_reg;
   logic               ready_reg;
   enc_state_e         enc_ctrl;

   logic [ROUND_W-1:0] num_rounds;
   logic [BLOCK_W-1:0] cur_block;
   logic [BLOCK_W-1:0] sr_block;
   logic [BLOCK_W-1:0] block_new;
   logic [3:0]         block_we;
   logic [WORD_W-1:0]  sbox_in;
   update_e            upd;

   assign num_rounds = keylen_reg ? AES256_ROUNDS : AES128_ROUNDS;
   assign cur_block  = {block_w0, block_w1, block_w2, block_w3};
   assign sr_block   = shiftrows(cur_block);

   assign bus.round     = round_ctr;
   assign bus.ready     = ready_reg;
   assign bus.new_block = cur_block;
   assign bus.sboxw     = (enc_ctrl == CTRL_SBOX) ? sbox_in : '0;

   always_comb begin
      sbox_in = block_w0;
      unique case (sword_ctr)
         2'd0: sbox_in = block_w0;
         2'd1: sbox_in = block_w1;
         2'd2: sbox_in = block_w2;
         2'd3: sbox_in = block_w3;
         default: sbox_in = block_w0;
      endcase
   end

   // Select the block update for this cycle and which words it writes.
   always_comb begin
      upd       = UPD_NONE;
      block_new = cur_block;
      block_we  = 4'b0000;
      unique case (enc_ctrl)
         CTRL_INIT: upd = UPD_INIT;
         CTRL_SBOX: upd = UPD_SBOX;
         CTRL_MAIN: upd = (round_ctr < num_rounds) ? UPD_MAIN : UPD_FINAL;
         default:   upd = UPD_NONE;
      endcase
      unique case (upd)
         UPD_INIT: begin
            block_new = addroundkey(bus.block, bus.round_key);
            block_we  = 4'b1111;
         end
         UPD_SBOX: begin
            block_new = {4{bus.new_sboxw}};
            block_we  = 4'b1000 >> sword_ctr;
         end
         UPD_MAIN: begin
            block_new = addroundkey(mixcolumns(sr_block), bus.round_key);
            block_we  = 4'b1111;
         end
         UPD_FINAL: begin
            block_new = addroundkey(sr_block, bus.round_key);
            block_we  = 4'b1111;
         end
         default: begin
            block_new = cur_block;
            block_we  = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         block_w0   <= '0;
         block_w1   <= '0;
         block_w2   <= '0;
         block_w3   <= '0;
      end else begin
         if (block_we[3]) block_w0 <= block_new[127:96];
         if (block_we[2]) block_w1 <= block_new[95:64];
         if (block_we[1]) block_w2 <= block_new[63:32];
         if (block_we[0]) block_w3 <= block_new[31:0];
      end
   end

   // Control FSM; round_ctr holds at the last round index instead of wrapping.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sword_ctr  <= '0;
         round_ctr  <= '0;
         keylen_reg <= 1'b0;
         ready_reg  <= 1'b1;
         enc_ctrl   <= CTRL_IDLE;
      end else begin
         unique case (enc_ctrl)
            CTRL_IDLE: begin
               if (bus.next) begin
                  round_ctr  <= '0;
                  keylen_reg <= bus.keylen;
                  ready_reg  <= 1'b0;
                  enc_ctrl   <= CTRL_INIT;
               end
            end
            CTRL_INIT: begin
               round_ctr <= ROUND_W'(1);
               sword_ctr <= '0;
               enc_ctrl  <= CTRL_SBOX;
            end
            CTRL_SBOX: begin
               sword_ctr <= sword_ctr + 2'd1;
               if (sword_ctr == 2'd3) enc_ctrl <= CTRL_MAIN;
            end
            CTRL_MAIN: begin
               sword_ctr <= '0;
               if (upd == UPD_FINAL) begin
                  ready_reg <= 1'b1;
                  enc_ctrl  <= CTRL_IDLE;
               end else begin
                  round_ctr <= round_ctr + ROUND_W'(1);
                  enc_ctrl  <= CTRL_SBOX;
               end
            end
            default: enc_ctrl <= CTRL_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_encipher_block.sv
// Self-checking bench: byte-level AES reference model compared every cycle,
// plus FIPS-197 / SP800-38A literal vectors and latency checks.
module tb_aes_encipher_block;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   aes_encipher_block_if bus ();

   aes_encipher_block dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   logic [7:0]   sbox_t [256];
   logic [127:0] rk_tab [16];
   logic [255:0] key_v = '0;
   time          t0 = 0;
   int           n_checks = 0;
   int           n_errors = 0;

   // Core-level shared S-box and key memory stand-ins.
   assign bus.new_sboxw = {sbox_t[bus.sboxw[31:24]], sbox_t[bus.sboxw[23:16]],
                           sbox_t[bus.sboxw[15:8]],  sbox_t[bus.sboxw[7:0]]};
   assign bus.round_key = rk_tab[bus.round];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [7:0] gb(input logic [127:0] v, input int i);
      return v[127-8*i -: 8];
   endfunction

   // Substitute the first nw words (byte 0 is the most significant byte).
   function automatic logic [127:0] sub_words(input logic [127:0] v, input int nw);
      logic [127:0] r;
      r = v;
      for (int i = 0; i < 4*nw; i++) r[127-8*i -: 8] = sbox_t[gb(v, i)];
      return r;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] v);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int w = 0; w < 4; w++)
            r[127-8*(w+4*c) -: 8] = gb(v, w + 4*((c + w) % 4));
      return r;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] v);
      logic [127:0] r;
      logic [7:0] a [4];
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int w = 0; w < 4; w++) a[w] = gb(v, 4*c + w);
         for (int w = 0; w < 4; w++)
            r[127-8*(4*c+w) -: 8] = gmul(8'h02, a[w]) ^ gmul(8'h03, a[(w+1)%4])
                                    ^ a[(w+2)%4] ^ a[(w+3)%4];
      end
      return r;
   endfunction

   function automatic logic [127:0] round_key_of(input logic [255:0] k, input logic kl, input int r);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rcon;
      int nk;
      nk = kl ? 8 : 4;
      for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
      rcon = 8'h01;
      for (int i = nk; i < 60; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'h0};
            rcon = gmul(rcon, 8'h02);
         end else if (nk == 8 && i % nk == 4) begin
            t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
         end
         w[i] = w[i-nk] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [255:0] k,
                                             input logic kl, input int r, input int nr);
      logic [127:0] t;
      t = shift_rows(sub_words(s, 4));
      if (r < nr) t = mix_columns(t);
      return t ^ round_key_of(k, kl, r);
   endfunction

   function automatic logic [127:0] aes_ref(input logic [255:0] k, input logic kl, input logic [127:0] pt);
      logic [127:0] s;
      int nr;
      nr = kl ? 14 : 10;
      s = pt ^ round_key_of(k, kl, 0);
      for (int r = 1; r <= nr; r++) s = round_fn(s, k, kl, r, nr);
      return s;
   endfunction

   // Reference model: k counts edges since acceptance (1 = INIT cycle).
   logic         model_ok = 1'b0;
   logic         m_busy = 1'b0;
   logic         m_fresh = 1'b1;
   logic         m_kl = 1'b0;
   int           m_k = 0;
   int           m_nr = 10;
   logic [127:0] m_result = '0;
   logic [127:0] m_st [16];

   always @(posedge clk) begin
      model_ok = 1'b1;
      if (!reset_n) begin
         m_busy = 1'b0; m_k = 0; m_result = '0; m_fresh = 1'b1;
      end else if (m_busy) begin
         m_k++;
         if (m_k == 2) begin
            m_st[1] = bus.block ^ round_key_of(key_v, m_kl, 0);
            for (int r = 1; r <= m_nr; r++) m_st[r+1] = round_fn(m_st[r], key_v, m_kl, r, m_nr);
         end
         if (m_k == 5*m_nr + 2) begin
            m_busy = 1'b0;
            m_result = m_st[m_nr+1];
         end
      end else if (bus.next) begin
         m_busy = 1'b1; m_k = 1; m_kl = bus.keylen; m_nr = bus.keylen ? 14 : 10; m_fresh = 1'b0;
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      logic [127:0] e_nb;
      logic [31:0]  e_sw;
      int j, r, p;
      if (model_ok) begin
         if (!m_busy || m_k == 1) begin
            e_sw = '0;
            e_nb = m_result;
            chk("ready", 128'(bus.ready), 128'(!m_busy));
            if (m_busy || m_fresh) chk("round_idle_init", 128'(bus.round), 128'(0));
         end else begin
            j = m_k - 2; r = j / 5 + 1; p = j % 5;
            chk("ready_busy", 128'(bus.ready), 128'(0));
            chk("round", 128'(bus.round), 128'(r));
            if (p < 4) begin
               e_sw = m_st[r][127-32*p -: 32];
               e_nb = sub_words(m_st[r], p);
            end else begin
               e_sw = '0;
               e_nb = sub_words(m_st[r], 4);
            end
         end
         chk("sboxw", 128'(bus.sboxw), 128'(e_sw));
         chk("new_block", bus.new_block, e_nb);
      end
   end

   task automatic start_op(input logic [255:0] k, input logic kl, input logic [127:0] pt, input bit hold);
      key_v = k;
      for (int r = 0; r < 16; r++) rk_tab[r] = (r < 15) ? round_key_of(k, kl, r) : '0;
      bus.keylen = kl;
      bus.block  = pt;
      bus.next   = 1'b1;
      @(negedge clk);
      t0 = $time;
      if (!hold) bus.next = 1'b0;
   endtask

   task automatic wait_done(input string name, input int exp_lat);
      int guard;
      guard = 0;
      while (bus.ready !== 1'b1 && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      if (bus.ready !== 1'b1) chk({name, "_timeout"}, 128'(0), 128'(1));
      chk({name, "_latency"}, 128'(($time - t0) / 10 + 1), 128'(exp_lat));
   endtask

   task automatic wait_round(input string name, input int r);
      int guard;
      guard = 0;
      while (bus.round != 4'(r) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (bus.round != 4'(r)) chk({name, "_round_timeout"}, 128'(bus.round), 128'(r));
   endtask

   localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] KEY_SP = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] PT_SP  = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] CT_SP  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

   initial begin
      logic [7:0] sb_idx;
      bus.next = 1'b0; bus.keylen = 1'b0; bus.block = '0;
      for (int r = 0; r < 16; r++) rk_tab[r] = '0;
      build_sbox();

      // Pin the reference model on known values.
      sb_idx = 8'h00; chk("model_sbox_00", 128'(sbox_t[sb_idx]), 128'h63);
      sb_idx = 8'h53; chk("model_sbox_53", 128'(sbox_t[sb_idx]), 128'hed);
      chk("model_c1", aes_ref(KEY_C1, 1'b0, PT_C), CT_C1);
      chk("model_c3", aes_ref(KEY_C3, 1'b1, PT_C), CT_C3);

      repeat (2) @(negedge clk);
      chk("rst_ready", 128'(bus.ready), 128'(1));
      chk("rst_new_block", bus.new_block, 128'(0));
      chk("rst_round", 128'(bus.round), 128'(0));
      reset_n = 1'b1;
      @(negedge clk);

      start_op(KEY_C1, 1'b0, PT_C, 1'b0);
      wait_done("c1", 52);
      chk("c1_ct", bus.new_block, CT_C1);

      @(negedge clk);
      start_op(KEY_C3, 1'b1, PT_C, 1'b0);
      wait_done("c3", 72);
      chk("c3_ct", bus.new_block, CT_C3);

      // Back-to-back with next held high.
      @(negedge clk);
      start_op(KEY_C1, 1'b0, PT_C, 1'b1);
      wait_done("b2b_c1", 52);
      chk("b2b_c1_ct", bus.new_block, CT_C1);
      start_op(KEY_SP, 1'b0, PT_SP, 1'b0);
      chk("b2b_restart_ready", 128'(bus.ready), 128'(0));
      wait_done("b2b_sp", 52);
      chk("b2b_sp_ct", bus.new_block, CT_SP);

      // Abort during round 5.
      @(negedge clk);
      start_op(KEY_C3, 1'b1, PT_SP, 1'b0);
      wait_round("abort", 5);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("abort_ready", 128'(bus.ready), 128'(1));
      chk("abort_new_block", bus.new_block, 128'(0));
      chk("abort_round", 128'(bus.round), 128'(0));
      start_op(KEY_C1, 1'b0, PT_C, 1'b0);
      wait_done("post_abort", 52);
      chk("post_abort_ct", bus.new_block, CT_C1);

      // next and keylen disturbed while busy.
      @(negedge clk);
      start_op(KEY_C3, 1'b1, PT_C, 1'b0);
      wait_round("busy_in", 3);
      bus.next = 1'b1; bus.keylen = 1'b0;
      @(negedge clk);
      bus.next = 1'b0;
      wait_done("busy_in", 72);
      chk("busy_in_ct", bus.new_block, CT_C3);

      for (int t = 0; t < 8; t++) begin
         logic [255:0] k;
         logic [127:0] pt;
         logic kl;
         for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
         for (int i = 0; i < 4; i++) pt[32*i +: 32] = $urandom;
         kl = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         start_op(k, kl, pt, 1'b0);
         wait_done("rand", kl ? 72 : 52);
         chk("rand_ct", bus.new_block, aes_ref(k, kl, pt));
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
